// File: rtl/freqmeter_pkg.sv
// freqmeter_pkg: slave register map, scheduler state encoding and config register indices.
package freqmeter_pkg;
  localparam logic [8:0] OFS_IE    = 9'h000;
  localparam logic [8:0] OFS_START = 9'h080;
  localparam logic [8:0] OFS_PER   = 9'h100;
  localparam logic [8:0] OFS_TICK  = 9'h180;
  localparam logic [1:0] CFG_CTRL   = 2'd0;
  localparam logic [1:0] CFG_ENABLE = 2'd1;
  localparam logic [1:0] CFG_LENGTH = 2'd2;
  typedef enum logic [3:0] {
    IDLE, INIT_IE, START, WAIT_IRQ, RD_STATUS, PICK, RD_PER, RD_TICK, EMIT, RESTART
  } state_t;
  function automatic logic [8:0] ch_adr(input logic [8:0] base, input logic [4:0] ch);
    return base + {2'b00, ch, 2'b00};
  endfunction
endpackage

// File: rtl/wb_master_port.sv
// wb_master_port: single-access Wishbone engine; done/err are combinational on the ack/timeout cycle
// so the caller can issue the next request immediately, leaving one idle bus cycle.
module wb_master_port #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [8:0]  adr,
  input  logic [31:0] wdat,
  output logic        done,
  output logic        err,
  output logic        cyc,
  output logic        stb,
  output logic        bus_we,
  output logic [8:0]  bus_adr,
  output logic [31:0] bus_dat,
  input  logic        ack
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign stb  = cyc;
  assign done = cyc & ack;
  assign err  = cyc & ~ack & (cnt == CW'(ACK_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc     <= 1'b0;
      bus_we  <= 1'b0;
      bus_adr <= '0;
      bus_dat <= '0;
      cnt     <= '0;
    end else if (cyc) begin
      cnt <= cnt + CW'(1);
      if (done || err) cyc <= 1'b0;
    end else if (req) begin
      cyc     <= 1'b1;
      bus_we  <= we;
      bus_adr <= adr;
      bus_dat <= wdat;
      cnt     <= '0;
    end
endmodule

// File: rtl/freqmeter_scheduler.sv
// freqmeter_scheduler: autonomous Wishbone master that keeps every enabled freqmeters channel
// measuring and streams each finished (periods, ticks) pair out in round-robin order.
module freqmeter_scheduler
  import freqmeter_pkg::*;
#(
  parameter int INPUTS_COUNT = 24,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_we_i,
  input  logic [1:0]  cfg_adr_i,
  input  logic [31:0] cfg_dat_i,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [8:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        irq_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [4:0]  res_ch_o,
  output logic [31:0] res_periods_o,
  output logic [31:0] res_ticks_o,
  output logic        busy_o,
  output logic        bus_err_o
);
  localparam int N = INPUTS_COUNT;
  localparam logic [4:0] LAST = 5'(N - 1);
  state_t state, nxt;
  logic run, req, we, done, err, found;
  logic [N-1:0] enable, act, pending, rot;
  logic [31:0] length, wdat;
  logic [8:0] adr;
  logic [4:0] ch, ptr, off, pick_ch;
  logic [5:0] sum;
  assign res_ch_o = ch;
  wb_master_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
    .clk(clk_i), .rst_n(rst_ni), .req(req), .we(we), .adr(adr), .wdat(wdat),
    .done(done), .err(err), .cyc(m_cyc_o), .stb(m_stb_o), .bus_we(m_we_o),
    .bus_adr(m_adr_o), .bus_dat(m_dat_o), .ack(m_ack_i)
  );
  // act is the mask the slave was last programmed with; ENABLE edits reach it only on START/RESTART
  assign rot = N'({pending, pending} >> ptr);
  assign sum = {1'b0, ptr} + {1'b0, off};
  always_comb begin
    found = |rot;
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = 5'(i);
    pick_ch = (sum >= 6'(N)) ? 5'(sum - 6'(N)) : sum[4:0];
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = (run && length != 0 && !bus_err_o) ? INIT_IE : IDLE;
      INIT_IE:   nxt = done ? (run ? START : IDLE) : INIT_IE;
      START:     nxt = (done || !act[ch]) ? (!run ? IDLE : ch == LAST ? WAIT_IRQ : START) : START;
      WAIT_IRQ:  nxt = !run ? IDLE : irq_i ? RD_STATUS : WAIT_IRQ;
      RD_STATUS: nxt = done ? (run ? PICK : IDLE) : RD_STATUS;
      PICK:      nxt = !run ? IDLE : found ? RD_PER : WAIT_IRQ;
      RD_PER:    nxt = done ? (run ? RD_TICK : IDLE) : RD_PER;
      RD_TICK:   nxt = done ? (run ? EMIT : IDLE) : RD_TICK;
      EMIT:      nxt = res_ready_i ? (run ? RESTART : IDLE) : EMIT;
      RESTART:   nxt = done ? (run ? PICK : IDLE) : RESTART;
      default:   nxt = IDLE;
    endcase
    if (err) nxt = IDLE;
  end
  always_comb begin
    req = (state inside {INIT_IE, RD_STATUS, RD_PER, RD_TICK, RESTART}) || (state == START && act[ch]);
    we = state inside {INIT_IE, START, RESTART};
    adr = (state == START || state == RESTART) ? ch_adr(OFS_START, ch) :
          (state == RD_PER) ? ch_adr(OFS_PER, ch) :
          (state == RD_TICK) ? ch_adr(OFS_TICK, ch) : OFS_IE;
    wdat = (state == INIT_IE) ? 32'(act) :
           (state == START || (state == RESTART && enable[ch])) ? length : '0;
    busy_o = state != IDLE;
    res_valid_o = state == EMIT;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      run <= 1'b0;
      enable <= '0;
      length <= '0;
      act <= '0;
      pending <= '0;
      ch <= '0;
      ptr <= '0;
      res_periods_o <= '0;
      res_ticks_o <= '0;
      bus_err_o <= 1'b0;
    end else begin
      if (cfg_we_i && cfg_adr_i == CFG_CTRL) run <= cfg_dat_i[0];
      if (cfg_we_i && cfg_adr_i == CFG_ENABLE) enable <= cfg_dat_i[N-1:0];
      if (cfg_we_i && cfg_adr_i == CFG_LENGTH) length <= cfg_dat_i;
      if (err) bus_err_o <= 1'b1;
      else if (cfg_we_i && cfg_adr_i == CFG_CTRL) bus_err_o <= 1'b0;
      if (state == IDLE && nxt == INIT_IE) act <= enable;
      if (state == INIT_IE) ch <= '0;
      if (state == START && (done || !act[ch])) ch <= ch + 5'd1;
      if (state == RD_STATUS && done) pending <= m_dat_i[N-1:0] & act;
      if (state == PICK) ch <= pick_ch;
      if (state == RD_PER && done) res_periods_o <= m_dat_i;
      if (state == RD_TICK && done) res_ticks_o <= m_dat_i;
      if (state == RESTART && done) begin
        pending[ch] <= 1'b0;
        act[ch] <= enable[ch];
        ptr <= (ch == LAST) ? '0 : ch + 5'd1;
      end
    end
endmodule

// File: tb/tb_freqmeter_scheduler.sv
// tb_freqmeter_scheduler: freqmeters slave model plus bus/result scoreboards around the scheduler.
module tb_freqmeter_scheduler;
  localparam logic [31:0] LEN = 32'd2;
  logic clk = 1'b0;
  logic rst_ni, cfg_we_i, m_ack_i, res_ready_i;
  logic [1:0] cfg_adr_i;
  logic [31:0] cfg_dat_i, m_dat_i;
  logic m_cyc_o, m_stb_o, m_we_o, res_valid_o, busy_o, bus_err_o, irq_i;
  logic [8:0] m_adr_o;
  logic [31:0] m_dat_o, res_periods_o, res_ticks_o;
  logic [4:0] res_ch_o;

  typedef struct packed {logic we; logic [8:0] adr; logic [31:0] dat;} bus_t;
  typedef struct packed {logic [4:0] ch; logic [31:0] per; logic [31:0] tick;} res_t;
  typedef struct {logic [31:0] status; int n; logic [4:0] c0; logic [4:0] c1;} round_t;

  bus_t bus_q[$];
  res_t res_q[$];
  round_t rounds[4];
  int nvec = 0, nerr = 0;

  logic [31:0] status, new_status, ie, per_base, tick_base;
  logic load, nack_start;

  always #5 clk = ~clk;

  freqmeter_scheduler dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_adr_i(cfg_adr_i), .cfg_dat_i(cfg_dat_i),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .irq_i(irq_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_ch_o(res_ch_o), .res_periods_o(res_periods_o),
    .res_ticks_o(res_ticks_o), .busy_o(busy_o), .bus_err_o(bus_err_o)
  );

  // freqmeters slave: one-cycle registered ack, PER read clears the channel's ready bit
  assign irq_i = |(status & ie);
  always @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      status <= '0;
      ie <= '0;
      m_ack_i <= 1'b0;
      m_dat_i <= '0;
    end else begin
      m_ack_i <= 1'b0;
      if (load) status <= new_status;
      if (m_cyc_o && m_stb_o && !m_ack_i && !(nack_start && m_we_o && m_adr_o[8:7] == 2'b01)) begin
        m_ack_i <= 1'b1;
        if (m_we_o) begin
          if (m_adr_o == 9'h000) ie <= m_dat_o;
        end else begin
          case (m_adr_o[8:7])
            2'b00: m_dat_i <= status;
            2'b10: begin
              m_dat_i <= per_base + 32'(m_adr_o[6:2]);
              status[m_adr_o[6:2]] <= 1'b0;
            end
            2'b11: m_dat_i <= tick_base + 32'(m_adr_o[6:2]);
            default: m_dat_i <= '0;
          endcase
        end
      end
    end

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] ca(input logic [8:0] b, input logic [4:0] c);
    return b + {2'b00, c, 2'b00};
  endfunction

  function automatic void exp_bus(input logic w, input logic [8:0] a, input logic [31:0] d);
    bus_q.push_back('{we: w, adr: a, dat: d});
  endfunction

  task automatic mon();
    bus_t e;
    res_t r;
    if (rst_ni && m_cyc_o && m_stb_o && m_ack_i) begin
      if (bus_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL bus_unexpected: got we=%0b adr=%h dat=%h, expected no access", m_we_o, m_adr_o, m_dat_o);
      end else begin
        e = bus_q.pop_front();
        chk("bus_txn", 96'({m_we_o, m_adr_o, m_we_o ? m_dat_o : 32'h0}), 96'(e));
      end
    end
    if (rst_ni && res_valid_o && res_ready_i) begin
      if (res_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL res_unexpected: got ch=%0d per=%h tick=%h, expected no result", res_ch_o, res_periods_o, res_ticks_o);
      end else begin
        r = res_q.pop_front();
        chk("result", 96'({res_ch_o, res_periods_o, res_ticks_o}), 96'(r));
      end
    end
  endtask

  task automatic cfg(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1 cfg_we_i = 1'b1; cfg_adr_i = a; cfg_dat_i = d;
    @(posedge clk); #1 cfg_we_i = 1'b0;
  endtask

  task automatic load_status(input logic [31:0] s);
    @(posedge clk); #1 new_status = s; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((bus_q.size() != 0 || res_q.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_drained"}, 96'(bus_q.size() + res_q.size()), 96'd0);
    bus_q.delete();
    res_q.delete();
    repeat (4) @(negedge clk);
    chk({name, "_waiting"}, 96'({m_cyc_o, busy_o, irq_i}), 96'b010);
  endtask

  task automatic wait_start_access();
    int k = 0;
    while (!(m_cyc_o && m_adr_o == 9'h080) && k < 80) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    logic [68:0] sv;
    logic stable;
    int n;
    logic [4:0] c;
    rounds[0] = '{32'h3, 2, 5'd0, 5'd1};
    rounds[1] = '{32'h1, 1, 5'd0, 5'd0};
    rounds[2] = '{32'h3, 2, 5'd1, 5'd0};
    rounds[3] = '{32'h2, 1, 5'd1, 5'd0};
    rst_ni = 1'b1; cfg_we_i = 1'b0; cfg_adr_i = '0; cfg_dat_i = '0; res_ready_i = 1'b1;
    new_status = '0; load = 1'b0; nack_start = 1'b0; per_base = '0; tick_base = '0;
    #1 rst_ni = 1'b0;
    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none
    repeat (3) @(negedge clk);
    chk("reset_bus", 96'({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, res_valid_o, busy_o, bus_err_o}), 96'd0);
    chk("reset_res", 96'({res_ch_o, res_periods_o, res_ticks_o}), 96'd0);
    @(posedge clk); #1 rst_ni = 1'b1;

    cfg(2'd1, 32'h3);
    cfg(2'd2, LEN);
    exp_bus(1'b1, 9'h000, 32'h3);
    exp_bus(1'b1, 9'h080, LEN);
    exp_bus(1'b1, 9'h084, LEN);
    cfg(2'd0, 32'h1);
    drain("init");

    for (int r = 0; r < 4; r++) begin
      per_base = 32'h10 + 32'(r) * 32'h100;
      tick_base = 32'h20 + 32'(r) * 32'h100;
      exp_bus(1'b0, 9'h000, 32'h0);
      for (int i = 0; i < rounds[r].n; i++) begin
        c = (i == 0) ? rounds[r].c0 : rounds[r].c1;
        exp_bus(1'b0, ca(9'h100, c), 32'h0);
        exp_bus(1'b0, ca(9'h180, c), 32'h0);
        exp_bus(1'b1, ca(9'h080, c), LEN);
        res_q.push_back('{ch: c, per: per_base + 32'(c), tick: tick_base + 32'(c)});
      end
      load_status(rounds[r].status);
      drain($sformatf("round%0d", r));
    end

    per_base = 32'h500; tick_base = 32'h600;
    exp_bus(1'b0, 9'h000, 32'h0);
    exp_bus(1'b0, 9'h100, 32'h0);
    exp_bus(1'b0, 9'h180, 32'h0);
    res_q.push_back('{ch: 5'd0, per: 32'h500, tick: 32'h600});
    res_ready_i = 1'b0;
    load_status(32'h1);
    n = 0;
    while (!res_valid_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", 96'(res_valid_o), 96'd1);
    sv = {res_ch_o, res_periods_o, res_ticks_o};
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid_o || m_cyc_o || {res_ch_o, res_periods_o, res_ticks_o} !== sv) stable = 1'b0;
    end
    chk("stall_stable", 96'(stable), 96'd1);
    chk("stall_data", 96'(sv), 96'({5'd0, 32'h500, 32'h600}));
    exp_bus(1'b1, 9'h080, LEN);
    @(posedge clk); #1 res_ready_i = 1'b1;
    drain("stall");

    cfg(2'd1, 32'h1);
    per_base = 32'h700; tick_base = 32'h800;
    exp_bus(1'b0, 9'h000, 32'h0);
    exp_bus(1'b0, 9'h104, 32'h0);
    exp_bus(1'b0, 9'h184, 32'h0);
    exp_bus(1'b1, 9'h084, 32'h0);
    res_q.push_back('{ch: 5'd1, per: 32'h701, tick: 32'h801});
    load_status(32'h2);
    drain("en_clear");

    cfg(2'd0, 32'h0);
    repeat (3) @(negedge clk);
    chk("stop_idle", 96'({busy_o, m_cyc_o}), 96'd0);

    nack_start = 1'b1;
    exp_bus(1'b1, 9'h000, 32'h1);
    cfg(2'd0, 32'h1);
    wait_start_access();
    chk("to_start", 96'({m_cyc_o, m_adr_o}), 96'({1'b1, 9'h080}));
    n = 0;
    while (m_cyc_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_len", 96'(n), 96'd16);
    chk("to_err", 96'({bus_err_o, busy_o, m_cyc_o, m_stb_o}), 96'b1000);
    repeat (5) @(negedge clk);
    chk("to_hold", 96'({bus_err_o, busy_o, m_cyc_o}), 96'b100);
    cfg(2'd0, 32'h0);
    @(negedge clk);
    chk("to_clear", 96'(bus_err_o), 96'd0);
    chk("to_queue", 96'(bus_q.size()), 96'd0);

    exp_bus(1'b1, 9'h000, 32'h1);
    cfg(2'd0, 32'h1);
    wait_start_access();
    chk("rst_mid_cyc", 96'(m_cyc_o), 96'd1);
    #2 rst_ni = 1'b0;
    #1 chk("rst_async", 96'({m_cyc_o, m_stb_o, busy_o}), 96'd0);
    chk("rst_outs", 96'({res_valid_o, bus_err_o, res_ch_o, res_periods_o, res_ticks_o}), 96'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    nack_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_idle", 96'({busy_o, m_cyc_o, bus_err_o}), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/freqmeter_scheduler.md
Name: freqmeter_scheduler

Overview:
- Wishbone master that runs the multi-channel freqmeters slave without CPU involvement.
- Initialises the IRQ mask, starts every enabled channel with a programmed measurement length, then waits for the freqmeters interrupt.
- On interrupt it reads the two result words of each ready channel and hands them out on a valid/ready stream.
- It then restarts that channel, giving a continuous, round-robin-fair sampling loop.

Parameters:
- INPUTS_COUNT, 24: number of freqmeters channels; legal range 1..32.
- ACK_TIMEOUT, 16: clk_i cycles to wait for m_ack_i before a bus transaction is aborted.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- cfg_we_i  in  1  single-cycle config write strobe.
- cfg_adr_i  in  2  config register select: 0=CTRL (bit0 run), 1=ENABLE mask, 2=LENGTH.
- cfg_dat_i  in  32  config write data.
- m_cyc_o  out  1  Wishbone cycle.
- m_stb_o  out  1  Wishbone strobe.
- m_we_o  out  1  Wishbone write enable.
- m_adr_o  out  9  Wishbone byte address.
- m_dat_o  out  32  Wishbone write data.
- m_dat_i  in  32  Wishbone read data.
- m_ack_i  in  1  Wishbone acknowledge.
- irq_i  in  1  freqmeters inta_o.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted.
- res_ch_o  out  5  result channel index.
- res_periods_o  out  32  word read from 0x100+4*ch.
- res_ticks_o  out  32  word read from 0x180+4*ch.
- busy_o  out  1  FSM not in IDLE.
- bus_err_o  out  1  sticky ack-timeout flag; cleared by writing CTRL.

Behaviour:
- Slave map:
  - 0x000 write = IRQ enable mask; 0x000 read = ready bitmap.
  - 0x080+4*ch write = start channel with N input periods; N=0 stops the channel.
  - 0x100+4*ch read = period count; this read clears the channel's ready bit.
  - 0x180+4*ch read = master tick count.
- Reset: all outputs 0, state IDLE, config registers 0, round-robin pointer 0. Reset asserted mid-transaction drops cyc/stb asynchronously.
- Bus cycle: drive cyc, stb, adr, we, dat together and hold until m_ack_i. Capture read data on the ack edge; deassert cyc/stb in the next cycle. Back-to-back accesses have one idle cycle between them.
- Timeout: if ACK_TIMEOUT cycles elapse without ack, abort the access, set bus_err_o, go to IDLE.
- FSM states: IDLE, INIT_IE, START, WAIT_IRQ, RD_STATUS, PICK, RD_PER, RD_TICK, EMIT, RESTART.
  - IDLE -> INIT_IE when CTRL.run=1 and LENGTH!=0.
  - INIT_IE: write ENABLE to 0x000.
  - START: write LENGTH to each enabled channel, ascending index.
  - WAIT_IRQ -> RD_STATUS on irq_i=1 (level).
  - RD_STATUS: latch ready bitmap & ENABLE into the pending register.
  - PICK: choose the first pending channel at or after the pointer, wrapping at INPUTS_COUNT-1 -> 0. None pending -> WAIT_IRQ.
  - RD_PER -> RD_TICK -> EMIT.
  - EMIT: assert res_valid_o with stable data until res_ready_i; the transfer completes on the valid&ready edge.
  - RESTART: write LENGTH, or 0 if the channel is now disabled, to 0x080+4*ch. Clear its pending bit, set pointer = ch+1 (wrap), return to PICK.
- Config writes are accepted in any state:
  - LENGTH and ENABLE changes take effect at the next START or RESTART.
  - Clearing CTRL.run finishes the current bus access and the EMIT handshake, then goes to IDLE without restarting channels.
- Latency: irq_i to first res_valid_o is at most 3 accesses plus PICK, 12 cycles with single-cycle ack.
- Status bits set for disabled channels are ignored.

Decomposition:
- Package freqmeter_pkg: slave offsets (IE 0x000, START 0x080, PER 0x100, TICK 0x180), FSM state enum, config register indices.
- Sub-module wb_master_port: a single-access Wishbone engine with request/done/err and timeout counter. It is reused by the FSM for every access.

Test Plan:
- Reset then ENABLE=0x000003, LENGTH=2, run=1 -> writes (0x000,0x3), (0x080,2), (0x084,2) in order, then idle waiting.
- Slave model raises irq, status=0x3, PER/TICK words 0x10/0x20 for ch0 and 0x11/0x21 for ch1 -> results emitted ch0 then ch1 with those values; restart writes to 0x080 and 0x084 with data 2.
- Round-robin: status 0x3 on two consecutive irqs after the pointer reaches 1 -> second round emits ch1 before ch0.
- res_ready_i held low 20 cycles -> res_valid_o and data stable, no bus activity until accepted.
- Clear ENABLE bit1 while in WAIT_IRQ, then irq with status 0x2 -> ch1 read, emitted, restart write data 0.
- Slave never acks the 0x080 write -> cyc/stb drop after 16 cycles, bus_err_o=1, FSM IDLE; a CTRL write clears the flag. Async reset mid-access drops cyc in the same cycle.
